// File: rtl/mlp_mul_pipe_fx.sv
// rtl/mlp_mul_pipe_fx.sv - elastic pipelined signed fixed-point multiplier
// Optional clamp-to-range narrowing is enabled with MLP_MUL_SAT_EN.
module mlp_mul_pipe_fx #(
   parameter int A_W       = 16,
   parameter int B_W       = 16,
   parameter int DOUT_W    = 16,
   parameter int FRAC_BITS = 0,
   parameter int NUM_STAGE = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [A_W-1:0]    a,
   input  logic signed [B_W-1:0]    b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DOUT_W-1:0] dout,
   output logic                     ovf
);
   localparam int PW   = A_W + B_W;
   localparam int RW   = PW + 1;
   localparam int LAST = NUM_STAGE - 1;

   logic [NUM_STAGE-1:0]     v_q;
   logic [NUM_STAGE-1:0]     adv;
   logic signed [A_W-1:0]    a_q;
   logic signed [B_W-1:0]    b_q;
   logic signed [PW-1:0]     prod;
   logic signed [PW-1:0]     prod_fin;
   logic signed [RW-1:0]     p_ext;
   logic signed [RW-1:0]     r_full;
   logic signed [DOUT_W-1:0] dout_d;
   logic signed [DOUT_W-1:0] dout_q;
   logic                     ovf_d;
   logic                     ovf_q;

   // Ready ripples back from the output: an empty stage always accepts.
   always_comb begin
      logic chain;
      adv   = '0;
      chain = out_ready;
      for (int k = LAST; k >= 0; k--) begin
         chain  = !v_q[k] || chain;
         adv[k] = chain;
      end
   end

   assign in_ready  = reset_n && adv[0];
   assign out_valid = v_q[LAST];
   assign dout      = dout_q;
   assign ovf       = ovf_q;
   assign prod      = PW'(a_q) * PW'(b_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (adv[0]) begin
            v_q[0] <= in_valid;
            a_q    <= a;
            b_q    <= b;
         end
         for (int k = 1; k < NUM_STAGE; k++) begin
            if (adv[k]) v_q[k] <= v_q[k-1];
         end
         if (adv[LAST]) begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   if (NUM_STAGE == 2) begin : g_fold
      assign prod_fin = prod;
   end else begin : g_delay
      logic signed [PW-1:0] p_q [1:NUM_STAGE-2];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 1; k <= NUM_STAGE - 2; k++) p_q[k] <= '0;
         end else begin
            if (adv[1]) p_q[1] <= prod;
            for (int k = 2; k <= NUM_STAGE - 2; k++) begin
               if (adv[k]) p_q[k] <= p_q[k-1];
            end
         end
      end

      assign prod_fin = p_q[NUM_STAGE-2];
   end

   // One guard bit so the half-LSB add can never wrap.
   assign p_ext = RW'(prod_fin);

   if (FRAC_BITS > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC_BITS - 1);
      assign r_full = (p_ext + HALF) >>> FRAC_BITS;
   end else begin : g_noround
      assign r_full = p_ext;
   end

`ifdef MLP_MUL_SAT_EN
   localparam logic signed [RW-1:0] MAX_V = {{(RW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

   always_comb begin
      dout_d = r_full[DOUT_W-1:0];
      ovf_d  = 1'b0;
      if (r_full > MAX_V) begin
         dout_d = MAX_V[DOUT_W-1:0];
         ovf_d  = 1'b1;
      end else if (r_full < MIN_V) begin
         dout_d = MIN_V[DOUT_W-1:0];
         ovf_d  = 1'b1;
      end
   end
`else
   logic unused_r_hi;
   assign unused_r_hi = ^r_full[RW-1:DOUT_W];
   assign dout_d      = r_full[DOUT_W-1:0];
   assign ovf_d       = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_mul_pipe_fx.sv
// tb/tb_mlp_mul_pipe_fx.sv - directed self-checking bench for mlp_mul_pipe_fx
// A second instance with FRAC_BITS=8 shares the handshake inputs for the rounding vectors.
module tb_mlp_mul_pipe_fx;
   logic               clk;
   logic               reset_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] a;
   logic signed [15:0] b;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] dout;
   logic               ovf;
   logic               rnd_in_ready;
   logic               rnd_out_valid;
   logic signed [15:0] rnd_dout;
   logic               rnd_ovf;

   int n_checks = 0;
   int n_errors = 0;
   int n_out    = 0;
   int exp_q[$];
   int exp_ovf_q[$];
   int mr, mo;

   logic               s_took, s_ir, s_ov, s_of;
   logic signed [15:0] s_d, s_d2;

   mlp_mul_pipe_fx dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf)
   );

   mlp_mul_pipe_fx #(.FRAC_BITS(8)) dut_rnd (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rnd_in_ready),
      .a(a), .b(b), .out_valid(rnd_out_valid), .out_ready(out_ready), .dout(rnd_dout),
      .ovf(rnd_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model(input int x, input int y, output int r, output int o);
      longint p;
      p = longint'(x) * longint'(y);
`ifdef MLP_MUL_SAT_EN
      if (p > 32767) begin
         r = 32767; o = 1;
      end else if (p < -32768) begin
         r = -32768; o = 1;
      end else begin
         r = int'(p); o = 0;
      end
`else
      r = int'($signed(p[15:0]));
      o = 0;
`endif
   endfunction

   // One cycle: drive after the edge, snapshot at the falling edge, return just after the next edge.
   task automatic step(input bit v, input bit r, input int x, input int y);
      in_valid  = v;
      out_ready = r;
      a         = 16'(x);
      b         = 16'(y);
      @(negedge clk);
      s_took = v && in_ready;
      s_ir   = in_ready;
      s_ov   = out_valid;
      s_of   = ovf;
      s_d    = dout;
      s_d2   = rnd_dout;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (in_valid && in_ready) begin
            model(int'(a), int'(b), mr, mo);
            exp_q.push_back(mr);
            exp_ovf_q.push_back(mo);
         end
         if (out_valid) begin
            check_eq("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check_eq("sb_dout", dout, exp_q[0]);
               check_eq("sb_ovf", ovf, exp_ovf_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(exp_ovf_q.pop_front());
                  n_out++;
               end
            end
         end
      end
   end

   initial begin
      int k;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_dout", dout, 0);
      check_eq("rst_ovf", ovf, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // latency
      step(1, 1, 3, -5);
      check_eq("t1_accept", s_took, 1);
      for (int i = 1; i <= 4; i++) begin
         step(0, 1, 0, 0);
         check_eq("t1_latency", s_ov, (i == 4));
      end
      check_eq("t1_dout", s_d, -15);
      check_eq("t1_ovf", s_of, 0);
      step(0, 1, 0, 0);
      check_eq("t1_single", s_ov, 0);

      // throughput
      for (int i = 0; i < 24; i++) begin
         step(i < 16, 1, i, i + 1);
         if (i < 16) check_eq("t2_in_ready", s_ir, 1);
         check_eq("t2_stream", s_ov, (i >= 4 && i < 20));
      end

      // backpressure: fill, hold, then toggle out_ready
      k = 0;
      n_out = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 50 + k, -(3 + k));
         if (s_took) k++;
         if (i >= 4) begin
            check_eq("t3_hold_valid", s_ov, 1);
            check_eq("t3_hold_dout", s_d, -150);
         end
      end
      check_eq("t3_accepted", k, 4);
      step(1, 0, 50 + k, -(3 + k));
      check_eq("t3_full", s_ir, 0);
      for (int i = 0; i < 40; i++) begin
         step(k < 12, i[0], 50 + k, -(3 + k));
         if (s_took) k++;
      end
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
      check_eq("t3_in_total", k, 12);
      check_eq("t3_out_total", n_out, 12);
      check_eq("t3_drained", exp_q.size(), 0);
      check_eq("t3_idle", s_ov, 0);

      // bubble collapse under stall
      for (int i = 0; i < 7; i++) begin
         step(!(i == 2 || i == 3), 0, 20 + i, 5 - i);
         check_eq("t3_bubble_ready", s_ir, (i < 6));
      end
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
      check_eq("t3_bubble_drained", exp_q.size(), 0);

      // rounding on the FRAC_BITS=8 instance
      step(1, 1, 16'h0180, 16'h0100);
      step(1, 1, 1, 16'h0080);
      step(1, 1, -1, 16'h0080);
      for (int i = 3; i < 8; i++) begin
         step(0, 1, 0, 0);
         if (i == 4) check_eq("t4_round_exact", s_d2, 16'sh0180);
         if (i == 5) check_eq("t4_round_half", s_d2, 1);
         if (i == 6) check_eq("t4_round_neg", s_d2, 0);
      end

      // narrowing
      step(1, 1, 300, 300);
      step(1, 1, -32768, -32768);
      step(1, 1, -300, 300);
      for (int i = 3; i < 8; i++) begin
         step(0, 1, 0, 0);
`ifdef MLP_MUL_SAT_EN
         if (i == 4) begin check_eq("t5_pos_dout", s_d, 32767);  check_eq("t5_pos_ovf", s_of, 1); end
         if (i == 5) begin check_eq("t5_min_dout", s_d, 32767);  check_eq("t5_min_ovf", s_of, 1); end
         if (i == 6) begin check_eq("t5_neg_dout", s_d, -32768); check_eq("t5_neg_ovf", s_of, 1); end
`else
         if (i == 4) begin check_eq("t5_pos_dout", s_d, 24464);  check_eq("t5_pos_ovf", s_of, 0); end
         if (i == 5) begin check_eq("t5_min_dout", s_d, 0);      check_eq("t5_min_ovf", s_of, 0); end
         if (i == 6) begin check_eq("t5_neg_dout", s_d, -24464); check_eq("t5_neg_ovf", s_of, 0); end
`endif
      end

      // asynchronous reset with results in flight
      step(1, 0, 7, 8);
      step(1, 0, 9, 10);
      step(1, 0, 11, 12);
      step(0, 0, 0, 0);
      check_eq("t6_pre_valid", out_valid, 1);
      check_eq("t6_pre_dout", dout, 56);
      #2 reset_n = 1'b0;
      exp_q.delete();
      exp_ovf_q.delete();
      #1;
      check_eq("t6_rst_valid", out_valid, 0);
      check_eq("t6_rst_dout", dout, 0);
      check_eq("t6_rst_ready", in_ready, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0);
         check_eq("t6_no_stale", s_ov, 0);
         check_eq("t6_ready", s_ir, 1);
      end
      step(1, 1, 13, -14);
      for (int i = 1; i <= 4; i++) begin
         step(0, 1, 0, 0);
         check_eq("t6_post_valid", s_ov, (i == 4));
      end
      check_eq("t6_post_dout", s_d, -182);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
